// File: rtl/timer_pkg.sv
// Shared timing/control definitions: FSM state encoding and default counter width.
package timer_pkg;
    localparam int DEF_WIDTH = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } state_t;
endpackage

// File: rtl/countdown_core.sv
// WIDTH-bit loadable down-counter datapath; is_one warns that the next decrement expires.
module countdown_core
    import timer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             dec,
    input  logic [WIDTH-1:0] val,
    output logic [WIDTH-1:0] count,
    output logic             is_one
);
    always_ff @(posedge clk) begin
        if (!rst_n)
            count <= '0;
        else if (load)
            count <= val;
        else if (dec && count != '0)
            count <= count - WIDTH'(1);
    end

    assign is_one = (count == WIDTH'(1));
endmodule

// File: rtl/countdown_timer.sv
// One-shot countdown timer with DONE/ACK handshake.
// Define AUTO_RELOAD_EN for periodic mode: reload on expiry with a one-cycle DONE pulse.
module countdown_timer
    import timer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] LOAD_VAL,
    input  logic             E,
    input  logic             ACK,
    output logic [WIDTH-1:0] COUNT,
    output logic             BUSY,
    output logic             DONE
);
    state_t           state;
    logic             is_one;
    logic             expire;
    logic             core_load;
    logic [WIDTH-1:0] core_val;

    // Expiry is detected on the decrementing edge so DONE lands with COUNT reaching 0.
    assign expire = (state == RUN) && E && is_one && !LOAD;

`ifdef AUTO_RELOAD_EN
    logic [WIDTH-1:0] reload_q;
    assign core_load = LOAD || expire;
    assign core_val  = LOAD ? LOAD_VAL : reload_q;
`else
    assign core_load = LOAD;
    assign core_val  = LOAD_VAL;
`endif

    countdown_core #(.WIDTH(WIDTH)) u_core (
        .clk    (CLK),
        .rst_n  (RESET_N),
        .load   (core_load),
        .dec    ((state == RUN) && E && !LOAD),
        .val    (core_val),
        .count  (COUNT),
        .is_one (is_one)
    );

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state <= IDLE;
            BUSY  <= 1'b0;
            DONE  <= 1'b0;
`ifdef AUTO_RELOAD_EN
            reload_q <= '0;
`endif
        end else if (LOAD) begin
`ifdef AUTO_RELOAD_EN
            reload_q <= LOAD_VAL;
`endif
            if (LOAD_VAL != '0) begin
                state <= RUN;
                BUSY  <= 1'b1;
                DONE  <= 1'b0;
            end else begin
                state <= EXPIRED;
                BUSY  <= 1'b0;
                DONE  <= 1'b1;
            end
        end else begin
            DONE <= 1'b0;
            case (state)
                RUN: begin
                    if (expire) begin
                        DONE <= 1'b1;
`ifndef AUTO_RELOAD_EN
                        state <= EXPIRED;
                        BUSY  <= 1'b0;
`endif
                    end
                end
                EXPIRED: begin
                    if (ACK)
                        state <= IDLE;
                    else
                        DONE <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
Loadable down-counting timer, the counterpart of the team's 3-bit enabled up-counter: that block measures elapsed ticks, this one consumes a tick budget. It is loaded with a tick count, decrements on each enabled cycle, and flags expiry to a controller. DONE is held until the controller acknowledges it. The block sits beside the up-counter in the datapath timing/control logic.

Parameters:
WIDTH, 3, bit width of COUNT and LOAD_VAL (max budget 2^WIDTH-1 ticks)

Ports:
CLK  input  1  clock; all logic on posedge
RESET_N  input  1  synchronous active-low reset, sampled on posedge CLK
LOAD  input  1  load LOAD_VAL and (re)start the timer
LOAD_VAL  input  WIDTH  tick budget to load
E  input  1  tick enable; decrement only when 1
ACK  input  1  controller acknowledge of DONE
COUNT  output  WIDTH  remaining ticks (registered)
BUSY  output  1  1 while in RUN
DONE  output  1  expiry flag (registered)

Behaviour:
- Reset: RESET_N=0 at a posedge -> state IDLE, COUNT=0, BUSY=0, DONE=0, internal reload register=0. Reset overrides every other input, including mid-RUN and mid-EXPIRED.
- States: IDLE, RUN, EXPIRED. BUSY=1 iff state==RUN. DONE=1 iff state==EXPIRED (default build).
- IDLE:
  - LOAD=1, LOAD_VAL!=0 -> COUNT<=LOAD_VAL; reload reg<=LOAD_VAL; -> RUN.
  - LOAD=1, LOAD_VAL==0 -> COUNT<=0; -> EXPIRED. DONE is high the next cycle.
  - Otherwise hold. E and ACK are ignored.
- RUN:
  - LOAD=1 restarts with the rules above. LOAD has priority over E.
  - E=1, COUNT>1 -> COUNT<=COUNT-1.
  - E=1, COUNT==1 -> COUNT<=0; -> EXPIRED.
  - E=0 -> hold.
  - Latency: from load of N with E held at 1, DONE rises N cycles after the LOAD edge.
- EXPIRED:
  - COUNT holds 0. It never wraps below 0. E is ignored.
  - LOAD=1 -> restart per the IDLE rules. LOAD has priority over ACK.
  - ACK=1 (and LOAD=0) -> IDLE, DONE=0 the next cycle.
  - No ACK -> DONE stays high indefinitely.
- Arithmetic: unsigned, WIDTH bits. Decrement only occurs when COUNT>=1.
- Simultaneous LOAD+E+ACK in any state: LOAD wins.

Optional Feature:
AUTO_RELOAD_EN
- Defined:
  - At expiry in RUN (E=1, COUNT==1): COUNT<=reload reg, stay in RUN. DONE pulses high for exactly one cycle, and ACK is not required.
  - A load of 0 still enters EXPIRED and waits for ACK, as in the default build.
  - LOAD updates the reload reg.
  - DONE becomes a registered pulse that is not state-derived while in RUN.
- Undefined: behaviour exactly as described above, one-shot with ACK handshake. The reload reg may be optimised away.

Decomposition:
- Shared package `timer_pkg`: state encoding constants (IDLE=2'd0, RUN=2'd1, EXPIRED=2'd2) and the default WIDTH constant, shared with the up-counter bench.
- One natural sub-module: `countdown_core`. It is the WIDTH-bit loadable down-counter datapath with inputs load/dec/val, and outputs count plus a one-cycle-early `is_one` flag.
- The FSM stays in `countdown_timer`.

Test Plan:
1. RESET_N=0 for 2 cycles with LOAD=1, LOAD_VAL=5 -> COUNT=0, BUSY=0, DONE=0 throughout; no load taken.
2. LOAD with LOAD_VAL=3, then E=1 continuously -> COUNT 3,2,1,0; DONE=1 on the 3rd cycle after the load edge and held until ACK; ACK -> DONE=0, BUSY=0, IDLE.
3. LOAD 5, then E toggled 1,0,1,0 -> COUNT 5,4,4,3,3; no DONE.
4. LOAD with LOAD_VAL=0 -> DONE=1 next cycle, COUNT=0, BUSY=0; E=1 for 4 cycles leaves COUNT=0 (no wrap to 7).
5. In RUN at COUNT=2, assert LOAD (LOAD_VAL=6) with E=1 -> COUNT=6, not 1. In EXPIRED, assert LOAD=4 and ACK together -> RUN, COUNT=4, DONE=0.
6. (AUTO_RELOAD_EN) LOAD 2, E=1 held for 6 cycles -> COUNT 2,1,2,1,2,1; DONE one-cycle pulse at each reload; BUSY stays 1; ACK has no effect. Mid-run RESET_N=0 -> all outputs 0.
